// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - operand registers, status, iteration count and result handshake for the subtractive GCD engine
module gcd_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sel_A,
  input  logic             sel_B,
  input  logic             wr_A,
  input  logic             wr_B,
  input  logic             wr_res,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] result_iters,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             overrun
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [CNT_W-1:0] iter_cnt;
  logic             load;
  logic             step;

  // Both muxes read the pre-edge registers, so a simultaneous A-B / B-A is well defined.
  assign a_nxt = sel_A ? (a_q - b_q) : a_in;
  assign b_nxt = sel_B ? (b_q - a_q) : b_in;

  assign load = (wr_A & ~sel_A) | (wr_B & ~sel_B);
  assign step = (wr_A & sel_A) | (wr_B & sel_B);

  // A zero operand counts as "equal" so the controller always terminates.
  assign a_eq_b = (a_q == b_q) | (a_q == '0) | (b_q == '0);
  assign a_gt_b = (a_q > b_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (wr_A) a_q <= a_nxt;
      if (wr_B) b_q <= b_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt <= '0;
    end else if (load) begin
      iter_cnt <= '0;
    end else if (step && (iter_cnt != {CNT_W{1'b1}})) begin
      iter_cnt <= iter_cnt + CNT_W'(1);
    end
  end

  // A capture coinciding with an ack consumes the old result, so it is not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_iters <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (wr_res) begin
      result       <= a_q | b_q;
      result_iters <= iter_cnt;
      result_valid <= 1'b1;
      if (result_valid && !result_ack) overrun <= 1'b1;
    end else if (result_ack) begin
      result_valid <= 1'b0;
    end
  end

endmodule
